axi_rt_budget_arbiter: RTL

- Real-time bandwidth regulator and arbiter for the manager ports that feed the shared AXI crossbar when the RT-enabled SoC configuration is selected.
- Each manager gets a beat budget per refill period.
- Managers with enough budget left compete in round-robin for one downstream burst slot at a time.
- A burst's full length is reserved from the manager's budget at grant time.

---
 rtl/axi_rt_budget_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_rt_budget_arbiter.sv
// axi_rt_budget_arbiter
//   Real-time bandwidth regulator and round-robin arbiter for the managers
//   that feed the shared AXI crossbar. Every regulated manager owns a beat
//   budget that is refilled once per period. A burst is granted only when the
//   remaining budget covers the whole burst, and its full length is deducted
//   at grant time. One burst is in flight at a time.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   enable_i        regulation enable (0 = plain round-robin)
//   budget_i        per-manager beats per period   (NumMgr x BudgetWidth)
//   period_i        per-manager refill period       (NumMgr x PeriodWidth, 0 = unregulated)
//   req_i, len_i    burst request and length (beats-1), held until granted
//   beat_i, last_i  downstream beat accepted / last beat of burst
//   gnt_o           one-hot grant, held for the whole burst
//   exhausted_o     request pending but blocked by budget
//   budget_left_o   remaining budget per manager
//   stall_cnt_o     per-manager budget-stall cycle counters (NumMgr x 32)
//
// Optional feature
//   AXI_RT_BUDGET_STALL_CNT_EN : when defined, stall_cnt_o counts the cycles
//   each manager spends with exhausted_o high (saturating). When undefined,
//   no counters exist and stall_cnt_o is tied to zero.

module axi_rt_budget_arbiter #(
    parameter int unsigned NumMgr      = 4,
    parameter int unsigned BudgetWidth = 16,
    parameter int unsigned PeriodWidth = 16,
    parameter int unsigned LenWidth    = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [NumMgr*BudgetWidth-1:0] budget_i,
    input  logic [NumMgr*PeriodWidth-1:0] period_i,
    input  logic [NumMgr-1:0]             req_i,
    input  logic [NumMgr*LenWidth-1:0]    len_i,
    input  logic                          beat_i,
    input  logic                          last_i,
    output logic [NumMgr-1:0]             gnt_o,
    output logic [NumMgr-1:0]             exhausted_o,
    output logic [NumMgr*BudgetWidth-1:0] budget_left_o,
    output logic [NumMgr*32-1:0]          stall_cnt_o
);

    localparam int unsigned NeedWidth = BudgetWidth + 1;
    localparam int unsigned PtrWidth  = (NumMgr > 1) ? $clog2(NumMgr) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [NumMgr-1:0]      gnt_q, gnt_d;
    logic [PtrWidth-1:0]    ptr_q, ptr_d;
    logic [BudgetWidth-1:0] budget_left_q [NumMgr];
    logic [BudgetWidth-1:0] budget_left_d [NumMgr];
    logic [PeriodWidth-1:0] period_cnt_q  [NumMgr];
    logic [PeriodWidth-1:0] period_cnt_d  [NumMgr];

    logic [NeedWidth-1:0]   need [NumMgr];
    logic [NumMgr-1:0]      regulated;
    logic [NumMgr-1:0]      eligible;
    logic                   pick_valid;
    logic [PtrWidth-1:0]    pick_idx;
    int unsigned            scan_idx;
    logic                   grant_fire;

    // Need and eligibility, evaluated against the registered budget.
    always_comb begin
        for (int unsigned i = 0; i < NumMgr; i++) begin
            need[i]      = NeedWidth'(len_i[i*LenWidth +: LenWidth]) + NeedWidth'(1);
            regulated[i] = enable_i && (period_i[i*PeriodWidth +: PeriodWidth] != '0);
            eligible[i]  = req_i[i] &&
                           (!regulated[i] || ({1'b0, budget_left_q[i]} >= need[i]));
        end
    end

    assign exhausted_o = req_i & ~eligible;

    // Round-robin pick: first eligible index at or after the pointer, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int unsigned off = 0; off < NumMgr; off++) begin
            scan_idx = (32'(ptr_q) + off) % NumMgr;
            if (!pick_valid && eligible[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = PtrWidth'(scan_idx);
            end
        end
    end

    assign grant_fire = (state_q == IDLE) && pick_valid;

    // Grant FSM next state.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = NumMgr'(1) << pick_idx;
                    ptr_d   = (32'(pick_idx) == NumMgr - 1) ? '0 : pick_idx + PtrWidth'(1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (beat_i && last_i) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Budget and period bookkeeping. A refill lands first and the grant charge
    // is applied on top of it, so a coincident refill+grant yields budget-need
    // (clamped at zero when the burst is larger than the whole budget).
    always_comb begin
        for (int unsigned i = 0; i < NumMgr; i++) begin
            budget_left_d[i] = budget_left_q[i];
            period_cnt_d[i]  = period_cnt_q[i];
            if (!enable_i) begin
                budget_left_d[i] = budget_i[i*BudgetWidth +: BudgetWidth];
                period_cnt_d[i]  = period_i[i*PeriodWidth +: PeriodWidth];
            end else if (regulated[i]) begin
                // A counter at 0 can only come from a period that was 0 at its
                // last reload; treat it as an immediate refill point.
                if (period_cnt_q[i] <= PeriodWidth'(1)) begin
                    period_cnt_d[i]  = period_i[i*PeriodWidth +: PeriodWidth];
                    budget_left_d[i] = budget_i[i*BudgetWidth +: BudgetWidth];
                end else begin
                    period_cnt_d[i]  = period_cnt_q[i] - PeriodWidth'(1);
                end
                if (grant_fire && (32'(pick_idx) == i)) begin
                    if ({1'b0, budget_left_d[i]} >= need[i]) begin
                        budget_left_d[i] = budget_left_d[i] - need[i][BudgetWidth-1:0];
                    end else begin
                        budget_left_d[i] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            for (int unsigned i = 0; i < NumMgr; i++) begin
                budget_left_q[i] <= budget_i[i*BudgetWidth +: BudgetWidth];
                period_cnt_q[i]  <= period_i[i*PeriodWidth +: PeriodWidth];
            end
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            for (int unsigned i = 0; i < NumMgr; i++) begin
                budget_left_q[i] <= budget_left_d[i];
                period_cnt_q[i]  <= period_cnt_d[i];
            end
        end
    end

    assign gnt_o = gnt_q;

    always_comb begin
        for (int unsigned i = 0; i < NumMgr; i++) begin
            budget_left_o[i*BudgetWidth +: BudgetWidth] = budget_left_q[i];
        end
    end

`ifdef AXI_RT_BUDGET_STALL_CNT_EN
    logic [31:0] stall_cnt_q [NumMgr];
    logic [31:0] stall_cnt_d [NumMgr];

    always_comb begin
        for (int unsigned i = 0; i < NumMgr; i++) begin
            stall_cnt_d[i] = stall_cnt_q[i];
            if (exhausted_o[i] && (stall_cnt_q[i] != '1)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
            end
            stall_cnt_o[i*32 +: 32] = stall_cnt_q[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumMgr; i++) begin
                stall_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumMgr; i++) begin
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
        end
    end
`else
    assign stall_cnt_o = '0;
`endif

endmodule
